// File: rtl/hdmi_tmds_pkg.sv
// rtl/hdmi_tmds_pkg.sv - shared TMDS symbol types, symbol tables and helpers
package hdmi_tmds_pkg;

    // Symbol type carried through the encoder pipeline
    typedef enum logic [2:0] {
        TMDS_VIDEO  = 3'd0,
        TMDS_CTRL   = 3'd1,
        TMDS_TERC4  = 3'd2,
        TMDS_VGUARD = 3'd3,
        TMDS_DGUARD = 3'd4
    } tmds_mode_e;

    // Control symbols indexed by {c1,c0}
    localparam logic [9:0] CTRL_SYM [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    // TERC4 data-island symbols indexed by nibble
    localparam logic [9:0] TERC4_SYM [16] = '{
        10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
        10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
        10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
        10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
    };

    // Video leading guard band, one entry per channel
    localparam logic [9:0] VGUARD_SYM [3] = '{
        10'b1011001100, 10'b0100110011, 10'b1011001100
    };

    // Data-island guard band for channels 1 and 2 (channel 0 sends TERC4)
    localparam logic [9:0] DGUARD_SYM = 10'b0100110011;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - two-stage TMDS 8b/10b / control / TERC4 / guard symbol encoder
module tmds_encoder
    import hdmi_tmds_pkg::*;
#(
    parameter int CHANNEL = 0
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic [2:0] mode,
    input  logic [7:0] video_data,
    input  logic [1:0] control_data,
    input  logic [3:0] terc4_data,
    output logic [9:0] tmds
);

    localparam logic [1:0] CH_IDX = CHANNEL[1:0];

    tmds_mode_e        mode_d, mode_q;
    logic [8:0]        qm_d, qm_q;
    logic [3:0]        ones_d, ones_q;
    logic [1:0]        ctrl_d, ctrl_q;
    logic [3:0]        terc_d, terc_q;

    logic [9:0]        tmds_d, tmds_q;
    logic signed [5:0] cnt_d, cnt_q;

    // Stage 1: transition-minimise the pixel byte and normalise reserved modes to control
    always_comb begin : s1_comb
        logic [3:0] n1;
        logic       use_xnor;
        logic [8:0] qm;
        n1       = popcount8(video_data);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !video_data[0]);
        qm       = '0;
        qm[0]    = video_data[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ video_data[i]) : (qm[i-1] ^ video_data[i]);
        end
        qm[8]  = ~use_xnor;
        qm_d   = qm;
        ones_d = popcount8(qm[7:0]);
        mode_d = (mode > 3'd4) ? TMDS_CTRL : tmds_mode_e'(mode);
        ctrl_d = control_data;
        terc_d = terc4_data;
    end

    // Stage 1 registers; reset loads a control-00 bubble
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            mode_q <= TMDS_CTRL;
            qm_q   <= '0;
            ones_q <= '0;
            ctrl_q <= '0;
            terc_q <= '0;
        end else begin
            mode_q <= mode_d;
            qm_q   <= qm_d;
            ones_q <= ones_d;
            ctrl_q <= ctrl_d;
            terc_q <= terc_d;
        end
    end

    // Stage 2: DC balancing for video, table lookup for everything else
    always_comb begin : s2_comb
        logic signed [5:0] diff;
        logic              q8;
        diff   = $signed({1'b0, ones_q, 1'b0}) - 6'sd8;
        q8     = qm_q[8];
        tmds_d = CTRL_SYM[ctrl_q];
        cnt_d  = '0;
        case (mode_q)
            TMDS_VIDEO: begin
                if ((cnt_q == 6'sd0) || (diff == 6'sd0)) begin
                    tmds_d = {~q8, q8, q8 ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d  = q8 ? (cnt_q + diff) : (cnt_q - diff);
                end else if ((cnt_q > 6'sd0 && diff > 6'sd0) ||
                             (cnt_q < 6'sd0 && diff < 6'sd0)) begin
                    tmds_d = {1'b1, q8, ~qm_q[7:0]};
                    cnt_d  = cnt_q + (q8 ? 6'sd2 : 6'sd0) - diff;
                end else begin
                    tmds_d = {1'b0, q8, qm_q[7:0]};
                    cnt_d  = cnt_q - (q8 ? 6'sd0 : 6'sd2) + diff;
                end
            end
            TMDS_TERC4:  tmds_d = TERC4_SYM[terc_q];
            TMDS_VGUARD: tmds_d = VGUARD_SYM[CH_IDX];
            TMDS_DGUARD: tmds_d = (CHANNEL == 0) ? TERC4_SYM[terc_q] : DGUARD_SYM;
            default:     tmds_d = CTRL_SYM[ctrl_q];
        endcase
    end

    // Stage 2 registers: output symbol and running disparity
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            tmds_q <= CTRL_SYM[0];
            cnt_q  <= '0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule
